// File: rtl/uart_rx_fifo.sv
// UART receiver with a first-word-fall-through receive FIFO.
// The line is synchronised, oversampled at mid-bit using a tick counter,
// and each complete frame is pushed as {perr, ferr, data}. A frame whose
// data, parity and stop samples are all zero is reported as a line break
// instead, and the receiver then waits for the line to go high again.
module uart_rx_fifo #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic [PAYLOAD_BITS-1:0] rd_data,
  output logic                    rd_perr,
  output logic                    rd_ferr,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    uart_rx_break,
  output logic                    overrun
);

  localparam int BAUD_TICKS = CLK_HZ / BIT_RATE;
  localparam int HALF       = BAUD_TICKS / 2;
  localparam int CNT_W      = $clog2(BAUD_TICKS + 1);
  localparam int BIT_W      = $clog2(PAYLOAD_BITS + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int OCC_W      = PTR_W + 1;
  localparam int ENTRY_W    = PAYLOAD_BITS + 2;

  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(BAUD_TICKS - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic             LAST_STOP   = 1'(STOP_BITS - 1);
  localparam logic [OCC_W-1:0] FULL_COUNT  = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRKWAIT
  } state_e;

  // Receiver state
  logic                    rxd_meta_q, rxs_q;
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        tick_q, tick_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    stop_q, stop_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    par_q, par_d;
  logic                    ferr_q, ferr_d;
  logic                    brk_q, brk_d;
  logic                    ovr_q, ovr_d;

  // Frame completion strobes from the receiver to the FIFO
  logic                    frame_done;
  logic                    ferr_final;
  logic                    perr;
  logic                    par_xor;

  // FIFO state
  logic [ENTRY_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]        count_q, count_d;
  logic                    full, empty, push, pop;
  logic [ENTRY_W-1:0]      head;

  // Two-flop synchroniser on the asynchronous serial line, idling high.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_meta_q <= 1'b1;
      rxs_q      <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxs_q      <= rxd_meta_q;
    end
  end

  // Receiver register bank.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
      ovr_q   <= ovr_d;
    end
  end

  // Parity check against the configured mode; zero when parity is disabled.
  always_comb begin
    par_xor = ^{data_q, par_q};
    if (PARITY == 1)      perr = ~par_xor;
    else if (PARITY == 2) perr = par_xor;
    else                  perr = 1'b0;
  end

  // Receiver next-state: mid-bit sampling, break detection and frame completion.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    data_d     = data_q;
    par_d      = par_q;
    ferr_d     = ferr_q;
    brk_d      = 1'b0;
    frame_done = 1'b0;
    ferr_final = ferr_q | ~rxs_q;

    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q && uart_rx_en) begin
          state_d = S_START;
          tick_d  = HALF_RELOAD;
        end
      end
      S_START: begin
        if (tick_q == '0) begin
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            tick_d  = BAUD_RELOAD;
            bit_d   = '0;
            stop_d  = 1'b0;
            data_d  = '0;
            par_d   = 1'b0;
            ferr_d  = 1'b0;
          end
        end else begin
          tick_d = tick_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (tick_q == '0) begin
          // LSB arrives first, so shifting in from the top leaves it at bit 0.
          data_d = {rxs_q, data_q[PAYLOAD_BITS-1:1]};
          tick_d = BAUD_RELOAD;
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          tick_d = tick_q - CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (tick_q == '0) begin
          par_d   = rxs_q;
          tick_d  = BAUD_RELOAD;
          state_d = S_STOP;
        end else begin
          tick_d = tick_q - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (tick_q == '0) begin
          ferr_d = ferr_final;
          if (stop_q == LAST_STOP) begin
            if (data_q == '0 && (PARITY == 0 || !par_q) && ferr_final) begin
              brk_d   = 1'b1;
              state_d = S_BRKWAIT;
            end else begin
              frame_done = 1'b1;
              state_d    = S_IDLE;
            end
          end else begin
            stop_d = 1'b1;
            tick_d = BAUD_RELOAD;
          end
        end else begin
          tick_d = tick_q - CNT_W'(1);
        end
      end
      S_BRKWAIT: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO handshake: a full FIFO still accepts a frame when the head leaves this cycle.
  always_comb begin
    full    = (count_q == FULL_COUNT);
    empty   = (count_q == '0);
    pop     = !empty && rd_ready;
    push    = frame_done && (!full || pop);
    ovr_d   = frame_done && full && !pop;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + OCC_W'(1);
    else if (pop && !push) count_d = count_q - OCC_W'(1);
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage written on accepted pushes.
  // NOTE: storage is left unreset; the output mux below hides stale contents while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {perr, ferr_final, data_q};
  end

  // Head-of-FIFO presentation, forced to zero while empty.
  always_comb begin
    head                        = empty ? '0 : mem_q[rd_ptr_q];
    {rd_perr, rd_ferr, rd_data} = head;
    rd_valid                    = !empty;
    uart_rx_break               = brk_q;
    overrun                     = ovr_q;
  end

endmodule
